// File: rtl/display_7seg_scan.sv
// Time-multiplexed 7-segment scanner: shadow/display double buffer swapped at frame boundaries,
// per-slot anti-ghost guard, leading-zero suppression, decimal points and per-digit blink.
module display_7seg_scan #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_en,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BL_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]   GUARD_V   = SLOT_W'(GUARD);
    localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
    localparam logic [BL_W-1:0]     BL_LAST   = BL_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]          SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF    = SEG_ACT_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF    = AN_ACT_LOW ? '1 : '0;

    // Active-low segment code {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_code(input logic [3:0] h);
        case (h)
            4'h0: hex_code = 7'h40;
            4'h1: hex_code = 7'h79;
            4'h2: hex_code = 7'h24;
            4'h3: hex_code = 7'h30;
            4'h4: hex_code = 7'h19;
            4'h5: hex_code = 7'h12;
            4'h6: hex_code = 7'h02;
            4'h7: hex_code = 7'h78;
            4'h8: hex_code = 7'h00;
            4'h9: hex_code = 7'h10;
            4'hA: hex_code = 7'h08;
            4'hB: hex_code = 7'h03;
            4'hC: hex_code = 7'h46;
            4'hD: hex_code = 7'h21;
            4'hE: hex_code = 7'h06;
            default: hex_code = 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] seg_drive(input logic [6:0] code_low);
        seg_drive = SEG_ACT_LOW ? code_low : ~code_low;
    endfunction

    logic [SLOT_W-1:0]     slot_cnt;
    logic [DIG_W-1:0]      dig_idx;
    logic [BL_W-1:0]       blink_cnt;
    logic                  blink_phase;
    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dp;
    logic                  slot_tc;
    logic                  frame_bnd;

    assign slot_tc    = (slot_cnt == SLOT_LAST);
    assign frame_bnd  = slot_tc && (dig_idx == DIG_LAST);
    assign frame_done = frame_bnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_tc) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Display only swaps at the frame boundary; a load landing on that cycle is taken directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_in;
            end
            if (frame_bnd) begin
                pending <= 1'b0;
                if (load) begin
                    disp_val <= value_in;
                    disp_dp  <= dp_in;
                end else if (pending) begin
                    disp_val <= shadow_val;
                    disp_dp  <= shadow_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_bnd) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    logic [3:0]          nib [N_DIGITS];
    logic [N_DIGITS-1:0] upper_zero;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_nib
        assign nib[k] = disp_val[4*k +: 4];
    end

    // upper_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[N_DIGITS-1] = (nib[N_DIGITS-1] == 4'd0);
        for (int k = N_DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = (nib[k] == 4'd0) && upper_zero[k+1];
        end
    end

    logic                lz_blank;
    logic                dark;
    logic                dp_on;
    logic [6:0]          code_low;
    logic [N_DIGITS-1:0] an_on;
    logic [6:0]          seg_p0;
    logic                dp_p0;
    logic [N_DIGITS-1:0] an_p0;

    always_comb begin
        lz_blank = lz_en && (dig_idx != '0) && upper_zero[dig_idx];
        dark     = blink_mask[dig_idx] && !blink_phase;
        code_low = (lz_blank || dark) ? 7'h7F : hex_code(nib[dig_idx]);
        dp_on    = disp_dp[dig_idx] && !dark;
        an_on    = (slot_cnt < GUARD_V) ? '0 : (N_DIGITS'(1) << dig_idx);
        seg_p0   = seg_drive(code_low);
        dp_p0    = SEG_ACT_LOW ? ~dp_on : dp_on;
        an_p0    = AN_ACT_LOW ? ~an_on : an_on;
    end

    // Output register stage: pins lag the scan state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_p0;
            dp  <= dp_p0;
            an  <= an_p0;
        end
    end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan with N=4, DIV=8, GUARD=2, BLINK_FRAMES=2 (32 cycles/frame).
module tb_display_7seg_scan;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    display_7seg_scan #(
        .N_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLINK_FRAMES(2),
        .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
        .lz_en(lz_en), .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an),
        .pending(pending), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    // cyc counts clock edges since the last reset release; outputs after edge t show scan state t-1.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic check_dig(input string tag, input int d, input logic [6:0] s, input logic p);
        logic [3:0] a;
        a = ~(4'b0001 << d);
        check({tag, ".an"}, 32'(an), 32'(a));
        check({tag, ".seg"}, 32'(seg), 32'(s));
        check({tag, ".dp"}, 32'(dp), 32'(p));
    endtask

    logic [6:0] f1_seg [4];
    logic [6:0] f2_seg [4];
    logic [6:0] f3_seg [4];

    initial begin
        f1_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        f2_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        f3_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};

        rst_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; lz_en = 1'b0; blink_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.seg", 32'(seg), 32'h7F);
        check("rst.dp", 32'(dp), 32'h1);
        check("rst.an", 32'(an), 32'hF);
        check("rst.pending", 32'(pending), 32'h0);
        check("rst.frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        run_to(2);
        check("guard.an", 32'(an), 32'hF);
        run_to(3);
        check_dig("first", 0, 7'h40, 1'b1);

        run_to(10);
        do_load(16'h12AF, 4'h0);
        check("load.pending", 32'(pending), 32'h1);
        run_to(14);
        check_dig("old_frame", 1, 7'h40, 1'b1);
        run_to(30);
        check("fd.low", 32'(frame_done), 32'h0);
        run_to(31);
        check("fd.high", 32'(frame_done), 32'h1);
        check("pend.before_bnd", 32'(pending), 32'h1);
        run_to(32);
        check("pend.after_bnd", 32'(pending), 32'h0);
        check("fd.pulse_end", 32'(frame_done), 32'h0);
        for (int d = 0; d < 4; d++) begin
            run_to(32 + 8*d + 1);
            check("f1.ghost.an", 32'(an), 32'hF);
            check("f1.ghost.seg", 32'(seg), 32'(f1_seg[d]));
            if (d == 0) begin
                run_to(32 + 2);
                check("f1.ghost2.an", 32'(an), 32'hF);
            end
            run_to(32 + 8*d + 6);
            check_dig("f1.dig", d, f1_seg[d], 1'b1);
        end

        lz_en = 1'b1;
        do_load(16'h0050, 4'h0);
        for (int d = 0; d < 4; d++) begin
            run_to(64 + 8*d + 6);
            check("lz50.seg", 32'(seg), 32'(f2_seg[d]));
        end
        do_load(16'h0000, 4'h0);
        for (int d = 0; d < 4; d++) begin
            run_to(96 + 8*d + 6);
            check("lz00.seg", 32'(seg), 32'(f3_seg[d]));
        end
        lz_en = 1'b0;

        run_to(140);
        do_load(16'h1111, 4'h0);
        check("mid.pending", 32'(pending), 32'h1);
        run_to(150);
        check_dig("mid.unchanged", 2, 7'h40, 1'b1);
        run_to(160);
        check("mid.pend_clr", 32'(pending), 32'h0);
        run_to(182);
        check_dig("mid.applied", 2, 7'h79, 1'b1);
        run_to(191);
        check("bndload.fd", 32'(frame_done), 32'h1);
        do_load(16'h3333, 4'h0);
        check("bndload.pending", 32'(pending), 32'h0);
        run_to(198);
        check_dig("bndload.shown", 0, 7'h30, 1'b1);
        run_to(200);
        do_load(16'h1111, 4'h0);
        run_to(210);
        do_load(16'h2222, 4'h0);
        check("last.pending", 32'(pending), 32'h1);
        run_to(214);
        check_dig("last.hold", 2, 7'h30, 1'b1);
        run_to(230);
        check_dig("last.d0", 0, 7'h24, 1'b1);
        run_to(238);
        check_dig("last.d1", 1, 7'h24, 1'b1);

        run_to(240);
        blink_mask = 4'b0001;
        do_load(16'h0008, 4'b0001);
        run_to(262);
        check_dig("blink.f8", 0, 7'h00, 1'b0);
        run_to(294);
        check_dig("blink.f9", 0, 7'h00, 1'b0);
        run_to(326);
        check_dig("blink.f10", 0, 7'h7F, 1'b1);
        run_to(334);
        check_dig("blink.f10.d1", 1, 7'h40, 1'b1);
        run_to(358);
        check_dig("blink.f11", 0, 7'h7F, 1'b1);
        run_to(390);
        check_dig("blink.f12", 0, 7'h00, 1'b0);

        run_to(396);
        do_load(16'h5555, 4'h0);
        run_to(403);
        check_dig("pre_arst", 2, 7'h40, 1'b1);
        check("pre_arst.pending", 32'(pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.seg", 32'(seg), 32'h7F);
        check("arst.dp", 32'(dp), 32'h1);
        check("arst.an", 32'(an), 32'hF);
        check("arst.pending", 32'(pending), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run_to(2);
        check("rearm.guard", 32'(an), 32'hF);
        run_to(3);
        check_dig("rearm.d0", 0, 7'h40, 1'b1);
        check("rearm.pending", 32'(pending), 32'h0);
        run_to(38);
        check_dig("rearm.f1", 0, 7'h40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
